// File: rtl/aes128_package.sv
// Shared definitions for the masked AES datapath: element types, LFSR width,
// randomness-source FSM states and the per-share-count randomness demand.
package aes128_package;

  typedef logic [1:0] bv2_t;

  localparam int LFSR_WIDTH = 128;

  typedef enum logic [1:0] {
    SEED,
    WARMUP,
    RUNNING
  } rs_state_t;

  // Random elements consumed by share_zero per cycle for a given share count.
  function automatic int num_needed(input int num_shares);
    case (num_shares)
      2:       return 1;
      3:       return 2;
      4:       return 4;
      5:       return 5;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/lfsr_advance.sv
// Combinational multi-step advance of the 128-bit masking LFSR.
// block[i] is the feedback bit produced by step i+1.
module lfsr_advance
  import aes128_package::*;
#(
  parameter int STEPS = 2
) (
  input  logic [LFSR_WIDTH-1:0] state,
  output logic [LFSR_WIDTH-1:0] next_state,
  output logic [STEPS-1:0]      block
);

  logic [LFSR_WIDTH-1:0] walk;
  logic                  fb;

  always_comb begin
    walk  = state;
    fb    = 1'b0;
    block = '0;
    for (int i = 0; i < STEPS; i++) begin
      fb       = walk[127] ^ walk[125] ^ walk[100] ^ walk[98];
      block[i] = fb;
      walk     = {walk[LFSR_WIDTH-2:0], fb};
    end
    next_state = walk;
  end

endmodule

// File: rtl/share_random_source.sv
// Masking-randomness generator: seeded 128-bit LFSR with warmup, delivering one
// OUT_BITS-wide random block per enabled cycle to share_zero.
module share_random_source
  import aes128_package::*;
#(
  parameter int  NUM_SHARES    = 2,
  parameter type T             = bv2_t,
  parameter int  WARMUP_CYCLES = 16,
  localparam int NUM_NEEDED    = num_needed(NUM_SHARES),
  localparam int OUT_BITS      = NUM_NEEDED * $bits(T)
) (
  input  logic                  in_clock,
  input  logic                  in_reset,
  input  logic [31:0]           in_seed,
  input  logic                  in_seed_valid,
  output logic                  out_seed_ready,
  input  logic                  in_reseed,
  input  logic                  in_enable,
  output T [NUM_NEEDED-1:0]     out_random,
  output logic                  out_valid
);

  localparam int SEED_WORDS = LFSR_WIDTH / 32;
  localparam int WCW        = $clog2(WARMUP_CYCLES + 1);
  localparam logic [WCW-1:0] WARM_LAST = WCW'(WARMUP_CYCLES - 1);

  rs_state_t             state_reg, state_next;
  logic [1:0]            word_cnt_reg, word_cnt_next;
  logic [WCW-1:0]        warm_cnt_reg, warm_cnt_next;
  logic [LFSR_WIDTH-1:0] s_reg, s_next;
  logic [OUT_BITS-1:0]   random_reg, random_next;
  logic                  valid_reg, valid_next;

  logic [LFSR_WIDTH-1:0] adv_state;
  logic [OUT_BITS-1:0]   adv_block;
  logic [LFSR_WIDTH-1:0] seed_merged;

  lfsr_advance #(
    .STEPS(OUT_BITS)
  ) u_advance (
    .state      (s_reg),
    .next_state (adv_state),
    .block      (adv_block)
  );

  // LFSR contents with the incoming seed word dropped into the slot addressed by k.
  for (genvar gi = 0; gi < SEED_WORDS; gi++) begin : g_seed_word
    assign seed_merged[32*gi +: 32] =
      (word_cnt_reg == 2'(gi)) ? in_seed : s_reg[32*gi +: 32];
  end

  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) begin
      state_reg    <= SEED;
      word_cnt_reg <= '0;
      warm_cnt_reg <= '0;
      s_reg        <= '0;
      random_reg   <= '0;
      valid_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      word_cnt_reg <= word_cnt_next;
      warm_cnt_reg <= warm_cnt_next;
      s_reg        <= s_next;
      random_reg   <= random_next;
      valid_reg    <= valid_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    word_cnt_next = word_cnt_reg;
    warm_cnt_next = warm_cnt_reg;
    s_next        = s_reg;
    random_next   = random_reg;
    valid_next    = valid_reg;

    case (state_reg)
      SEED: begin
        if (in_seed_valid) begin
          s_next        = seed_merged;
          word_cnt_next = word_cnt_reg + 2'd1;
          if (word_cnt_reg == 2'(SEED_WORDS - 1)) begin
            state_next    = WARMUP;
            warm_cnt_next = '0;
            // An all-zero LFSR would lock up; nudge it into the live cycle.
            if (seed_merged == '0) begin
              s_next = LFSR_WIDTH'(1);
            end
          end
        end
      end

      WARMUP: begin
        if (in_reseed) begin
          state_next    = SEED;
          word_cnt_next = '0;
          warm_cnt_next = '0;
          valid_next    = 1'b0;
        end else begin
          s_next      = adv_state;
          random_next = adv_block;
          if (warm_cnt_reg == WARM_LAST) begin
            state_next = RUNNING;
            valid_next = 1'b1;
          end else begin
            warm_cnt_next = warm_cnt_reg + 1'b1;
          end
        end
      end

      RUNNING: begin
        // Reseed wins over enable so the old sequence is not advanced on exit.
        if (in_reseed) begin
          state_next    = SEED;
          word_cnt_next = '0;
          warm_cnt_next = '0;
          valid_next    = 1'b0;
        end else if (in_enable) begin
          s_next      = adv_state;
          random_next = adv_block;
        end
      end

      default: begin
        state_next    = SEED;
        word_cnt_next = '0;
        warm_cnt_next = '0;
        valid_next    = 1'b0;
      end
    endcase
  end

  assign out_seed_ready = (state_reg == SEED);
  assign out_random     = random_reg;
  assign out_valid      = valid_reg;

endmodule

// File: tb/tb_share_random_source.sv
// Directed bench for share_random_source: several parameterisations share one
// stimulus stream; expected blocks come from a bit-serial LFSR reference.
module tb_share_random_source;

  logic        clk;
  logic        rst;
  logic [31:0] seed;
  logic        seed_valid;
  logic        reseed;
  logic        enable;

  logic        rdy2, vld2;
  logic [1:0]  rnd2;
  logic        rdy_w1, vld_w1;
  logic [1:0]  rnd_w1;
  logic        rdy3, vld3;
  logic [3:0]  rnd3;
  logic        rdy4, vld4;
  logic [7:0]  rnd4;
  logic        rdy5, vld5;
  logic [9:0]  rnd5;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [127:0] m2, m3, m4, m5;
  logic [63:0]  b2, b3, b4, b5;
  logic [1:0]   cur2;

  share_random_source #(.NUM_SHARES(2), .WARMUP_CYCLES(16)) dut (
    .in_clock(clk), .in_reset(rst), .in_seed(seed), .in_seed_valid(seed_valid),
    .out_seed_ready(rdy2), .in_reseed(reseed), .in_enable(enable),
    .out_random(rnd2), .out_valid(vld2));

  share_random_source #(.NUM_SHARES(2), .WARMUP_CYCLES(1)) dut_w1 (
    .in_clock(clk), .in_reset(rst), .in_seed(seed), .in_seed_valid(seed_valid),
    .out_seed_ready(rdy_w1), .in_reseed(reseed), .in_enable(enable),
    .out_random(rnd_w1), .out_valid(vld_w1));

  share_random_source #(.NUM_SHARES(3), .WARMUP_CYCLES(16)) dut3 (
    .in_clock(clk), .in_reset(rst), .in_seed(seed), .in_seed_valid(seed_valid),
    .out_seed_ready(rdy3), .in_reseed(reseed), .in_enable(enable),
    .out_random(rnd3), .out_valid(vld3));

  share_random_source #(.NUM_SHARES(4), .WARMUP_CYCLES(16)) dut4 (
    .in_clock(clk), .in_reset(rst), .in_seed(seed), .in_seed_valid(seed_valid),
    .out_seed_ready(rdy4), .in_reseed(reseed), .in_enable(enable),
    .out_random(rnd4), .out_valid(vld4));

  share_random_source #(.NUM_SHARES(5), .WARMUP_CYCLES(16)) dut5 (
    .in_clock(clk), .in_reset(rst), .in_seed(seed), .in_seed_valid(seed_valid),
    .out_seed_ready(rdy5), .in_reseed(reseed), .in_enable(enable),
    .out_random(rnd5), .out_valid(vld5));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bit-serial reference: n single steps, block bit i is the (i+1)-th feedback bit.
  task automatic model_adv(input logic [127:0] si, input int n,
                           output logic [127:0] so, output logic [63:0] blk);
    logic [127:0] s;
    logic         b;
    s   = si;
    blk = '0;
    for (int i = 0; i < n; i++) begin
      b      = s[127] ^ s[125] ^ s[100] ^ s[98];
      blk[i] = b;
      s      = {s[126:0], b};
    end
    so = s;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst        = 1'b1;
    seed       = '0;
    seed_valid = 1'b0;
    reseed     = 1'b0;
    enable     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    seed       = w;
    seed_valid = 1'b1;
    tick();
    seed_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst        = 1'b1;
    seed       = '0;
    seed_valid = 1'b0;
    reseed     = 1'b0;
    enable     = 1'b0;
    #1;
    total_cnt++;
    if (rdy2 !== 1'b1) $display("FAIL reset_ready: got %b expected 1", rdy2);
    else pass_cnt++;
    total_cnt++;
    if (vld2 !== 1'b0) $display("FAIL reset_valid: got %b expected 0", vld2);
    else pass_cnt++;
    total_cnt++;
    if (rnd5 !== 10'h000) $display("FAIL reset_random: got %h expected 000", rnd5);
    else pass_cnt++;
    do_reset();
  endtask

  task automatic test_zero_seed;
    do_reset();
    enable = 1'b1;
    repeat (4) send_word(32'h0);
    total_cnt++;
    if (rdy_w1 !== 1'b0 || vld_w1 !== 1'b0)
      $display("FAIL zero_enter_warmup: got ready=%b valid=%b expected ready=0 valid=0", rdy_w1, vld_w1);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (vld_w1 !== 1'b1) $display("FAIL zero_valid_rise: got %b expected 1", vld_w1);
    else pass_cnt++;
    for (int n = 1; n <= 49; n++) begin
      tick();
      total_cnt++;
      if (rnd_w1 !== ((n == 49) ? 2'b01 : 2'b00))
        $display("FAIL zero_block_%0d: got %b expected %b", n, rnd_w1, (n == 49) ? 2'b01 : 2'b00);
      else pass_cnt++;
    end
    enable = 1'b0;
  endtask

  task automatic test_seed_gaps;
    do_reset();
    enable = 1'b0;
    send_word(32'hDEADBEEF);
    tick();
    send_word(32'h01234567);
    tick();
    tick();
    total_cnt++;
    if (rdy2 !== 1'b1) $display("FAIL gap_ready_mid: got %b expected 1", rdy2);
    else pass_cnt++;
    send_word(32'h89ABCDEF);
    send_word(32'hCAFEF00D);
    total_cnt++;
    if (rdy2 !== 1'b0) $display("FAIL gap_ready_after: got %b expected 0", rdy2);
    else pass_cnt++;
    m2 = 128'hCAFEF00D_89ABCDEF_01234567_DEADBEEF;
    for (int c = 1; c <= 16; c++) begin
      tick();
      model_adv(m2, 2, m2, b2);
      total_cnt++;
      if (rnd2 !== b2[1:0]) $display("FAIL warmup_block_%0d: got %b expected %b", c, rnd2, b2[1:0]);
      else pass_cnt++;
      if (c >= 15) begin
        total_cnt++;
        if (vld2 !== (c == 16))
          $display("FAIL valid_timing_%0d: got %b expected %b", c, vld2, (c == 16));
        else pass_cnt++;
      end
    end
    enable = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      model_adv(m2, 2, m2, b2);
      total_cnt++;
      if (rnd2 !== b2[1:0]) $display("FAIL run_block_%0d: got %b expected %b", c, rnd2, b2[1:0]);
      else pass_cnt++;
    end
    cur2   = b2[1:0];
    enable = 1'b0;
  endtask

  task automatic test_enable_toggle;
    logic [5:0] pat;
    pat = 6'b011001;
    for (int c = 0; c < 6; c++) begin
      enable = pat[c];
      tick();
      if (pat[c]) begin
        model_adv(m2, 2, m2, b2);
        cur2 = b2[1:0];
      end
      total_cnt++;
      if (rnd2 !== cur2 || vld2 !== 1'b1)
        $display("FAIL enable_toggle_%0d: got rnd=%b valid=%b expected rnd=%b valid=1", c, rnd2, vld2, cur2);
      else pass_cnt++;
    end
    enable = 1'b0;
  endtask

  task automatic test_reseed;
    enable = 1'b1;
    reseed = 1'b1;
    tick();
    reseed = 1'b0;
    enable = 1'b0;
    total_cnt++;
    if (rnd2 !== cur2) $display("FAIL reseed_no_advance: got %b expected %b", rnd2, cur2);
    else pass_cnt++;
    total_cnt++;
    if (vld2 !== 1'b0 || rdy2 !== 1'b1)
      $display("FAIL reseed_flags: got valid=%b ready=%b expected valid=0 ready=1", vld2, rdy2);
    else pass_cnt++;
    send_word(32'hDEADBEEF);
    send_word(32'h01234567);
    send_word(32'h89ABCDEF);
    send_word(32'hCAFEF00D);
    m2 = 128'hCAFEF00D_89ABCDEF_01234567_DEADBEEF;
    for (int c = 1; c <= 16; c++) begin
      tick();
      model_adv(m2, 2, m2, b2);
    end
    total_cnt++;
    if (vld2 !== 1'b1 || rnd2 !== b2[1:0])
      $display("FAIL reseed_restart: got valid=%b rnd=%b expected valid=1 rnd=%b", vld2, rnd2, b2[1:0]);
    else pass_cnt++;
    enable = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      model_adv(m2, 2, m2, b2);
      total_cnt++;
      if (rnd2 !== b2[1:0]) $display("FAIL reseed_block_%0d: got %b expected %b", c, rnd2, b2[1:0]);
      else pass_cnt++;
    end
    enable = 1'b0;
  endtask

  task automatic test_async_reset;
    do_reset();
    send_word(32'h11111111);
    send_word(32'h22222222);
    send_word(32'h33333333);
    send_word(32'h44444444);
    repeat (3) tick();
    #2;
    rst = 1'b1;
    #1;
    total_cnt++;
    if (rnd5 !== 10'h000 || rnd2 !== 2'b00)
      $display("FAIL async_reset_random: got rnd5=%h rnd2=%b expected 000 00", rnd5, rnd2);
    else pass_cnt++;
    total_cnt++;
    if (vld2 !== 1'b0 || rdy2 !== 1'b1)
      $display("FAIL async_reset_flags: got valid=%b ready=%b expected valid=0 ready=1", vld2, rdy2);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    send_word(32'hA5A5A5A5);
    send_word(32'h5A5A5A5A);
    send_word(32'h0F0F0F0F);
    tick();
    total_cnt++;
    if (rdy2 !== 1'b1 || vld2 !== 1'b0)
      $display("FAIL async_partial: got ready=%b valid=%b expected ready=1 valid=0", rdy2, vld2);
    else pass_cnt++;
    send_word(32'hF0F0F0F0);
    total_cnt++;
    if (rdy2 !== 1'b0) $display("FAIL async_full_seed: got %b expected 0", rdy2);
    else pass_cnt++;
    m2 = 128'hF0F0F0F0_0F0F0F0F_5A5A5A5A_A5A5A5A5;
    for (int c = 1; c <= 16; c++) begin
      tick();
      model_adv(m2, 2, m2, b2);
    end
    total_cnt++;
    if (vld2 !== 1'b1 || rnd2 !== b2[1:0])
      $display("FAIL async_restart: got valid=%b rnd=%b expected valid=1 rnd=%b", vld2, rnd2, b2[1:0]);
    else pass_cnt++;
  endtask

  task automatic test_shares;
    do_reset();
    send_word(32'h13579BDF);
    send_word(32'h2468ACE0);
    reseed = 1'b1;
    tick();
    reseed = 1'b0;
    total_cnt++;
    if ({rdy3, rdy4, rdy5} !== 3'b111)
      $display("FAIL shares_ready_reseed: got %b expected 111", {rdy3, rdy4, rdy5});
    else pass_cnt++;
    send_word(32'hFEDCBA98);
    total_cnt++;
    if ({rdy3, rdy4, rdy5} !== 3'b111)
      $display("FAIL shares_ready_3words: got %b expected 111", {rdy3, rdy4, rdy5});
    else pass_cnt++;
    send_word(32'h76543210);
    total_cnt++;
    if ({rdy3, rdy4, rdy5} !== 3'b000)
      $display("FAIL shares_seed_done: got %b expected 000", {rdy3, rdy4, rdy5});
    else pass_cnt++;
    m3 = 128'h76543210_FEDCBA98_2468ACE0_13579BDF;
    m4 = m3;
    m5 = m3;
    for (int c = 1; c <= 16; c++) begin
      tick();
      model_adv(m3, 4, m3, b3);
      model_adv(m4, 8, m4, b4);
      model_adv(m5, 10, m5, b5);
    end
    total_cnt++;
    if ({vld3, vld4, vld5} !== 3'b111)
      $display("FAIL shares_valid: got %b expected 111", {vld3, vld4, vld5});
    else pass_cnt++;
    enable = 1'b1;
    for (int c = 0; c <= 3; c++) begin
      if (c > 0) begin
        tick();
        model_adv(m3, 4, m3, b3);
        model_adv(m4, 8, m4, b4);
        model_adv(m5, 10, m5, b5);
      end
      total_cnt++;
      if (rnd3 !== b3[3:0]) $display("FAIL shares3_block_%0d: got %h expected %h", c, rnd3, b3[3:0]);
      else pass_cnt++;
      total_cnt++;
      if (rnd4 !== b4[7:0]) $display("FAIL shares4_block_%0d: got %h expected %h", c, rnd4, b4[7:0]);
      else pass_cnt++;
      total_cnt++;
      if (rnd5 !== b5[9:0]) $display("FAIL shares5_block_%0d: got %h expected %h", c, rnd5, b5[9:0]);
      else pass_cnt++;
    end
    enable = 1'b0;
  endtask

  initial begin
    test_reset();
    test_zero_seed();
    test_seed_gaps();
    test_enable_toggle();
    test_reseed();
    test_async_reset();
    test_shares();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
